fetch_line_sequencer: RTL and testbench
=======================================

// Module: fetch_line_sequencer
// PURPOSE
//  Parametrised next-generation fetch line-address generator for a NUM_BANKS-way interleaved I$.
//  Picks the redirect source by priority: init > WB resteer > BP taken branch.
//  Keeps one line-address register per bank and advances each bank independently on accept.
//  Holds a bank's address through a miss, and tags each fetch stream with an epoch for stale-line filtering.
//  Sits between BP/WB redirect logic and the I$ banks, in front of the fetch-2 line latches.
// PARAMETERS
//  NUM_BANKS  2   banks, power of 2 (1,2,4,8); line LA maps to bank LA mod NUM_BANKS
//  LA_W       28  line-address width (byte address [31:4])
//  EPOCH_W    3   epoch tag width; wraps modulo 2**EPOCH_W
// PORTS
//  clk          in   1              clock, all state on rising edge
//  reset        in   1              asynchronous active-high reset
//  init_addr    in   32             byte address of the first fetch after boot
//  is_init      in   1              load init_addr as redirect target
//  is_resteer   in   1              WB resteer
//  wb_la        in   LA_W           resteer target line address
//  is_br_taken  in   1              BP predicted-taken branch
//  bp_la        in   LA_W           branch target line address
//  stall        in   1              downstream full; freezes every bank advance
//  bank_accept  in   NUM_BANKS      bank b line latched by fetch-2 this cycle
//  bank_miss    in   NUM_BANKS      bank b lookup missed this cycle
//  bank_req     out  NUM_BANKS      bank b address valid, request lookup
//  bank_la      out  NUM_BANKS*LA_W bank b line address, bank 0 in LSBs
//  epoch        out  EPOCH_W        current stream tag
//  redirect     out  1              registered pulse, 1 cycle after a redirect is taken
//  entry_off    out  4              byte offset within the line of the last redirect target
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; all bank_la=0; bank_req=0; epoch=0; redirect=0; entry_off=0.
//  Redirect and target:
//   - redirect_taken = is_init | (state!=IDLE & (is_resteer | is_br_taken)).
//   - Target T is selected by priority: init_addr[31:4] > wb_la > bp_la.
//   - entry_off = init_addr[3:0] on init, 0 otherwise.
//   - A redirect overrides stall, miss and accept in the same cycle.
//  Bank load on redirect:
//   - base = T with its low log2(NUM_BANKS) bits cleared; k = T mod NUM_BANKS.
//   - bank_la[b] <= base+b when b>=k, else base+NUM_BANKS+b.
//   - Every bank gets the first line at or after T that maps to it.
//   - Additions are modulo 2**LA_W and wrap silently.
//  Epoch and redirect outputs:
//   - On a redirect: epoch <= epoch+1, and redirect=1 on the next cycle.
//  FSM:
//   - IDLE: bank_req=0; ignores resteer and branch; is_init -> RUN.
//   - RUN: bank_req=all ones.
//     - Bank b advances (bank_la[b] += NUM_BANKS) iff bank_accept[b] & ~bank_miss[b] & ~stall & ~redirect_taken.
//     - Banks advance independently.
//     - Any bank_miss with no redirect -> MISS.
//   - MISS: bank_req stays 1 and bank_la does not advance for missed banks.
//     - A bank that is not missing may still advance on accept.
//     - bank_miss==0 -> RUN.
//     - A redirect returns to RUN with the new addresses.
//   - stall=1 in RUN or MISS: no bank advances; bank_req and addresses held.
//  Other rules:
//   - is_init is honoured in any state, including re-init while running.
//   - bank_accept and bank_miss on the same bank: the miss wins, no advance.
//   - The async reset may assert mid-stream and returns to the reset values immediately.
//   - NUM_BANKS=1: every redirect loads T itself; each accept advances by 1.
// TESTING
//  - Reset, then is_init with init_addr=0x0000_0014, NUM_BANKS=2 -> next cycle bank_la0=0x2, bank_la1=0x1, entry_off=4, epoch=1, redirect=1, bank_req=2'b11.
//  - NUM_BANKS=4, wb resteer to la=0x102 -> bank_la={0x103,0x102,0x105,0x104} for banks 3..0; BP taken in the same cycle is ignored.
//  - Steady RUN, accept bank 0 only for 3 cycles -> bank_la0 += 6 total, bank_la1 unchanged.
//  - bank_miss[1] for 5 cycles with bank_accept=2'b11 -> bank_la1 frozen, bank_la0 advances; state MISS, then RUN when the miss clears.
//  - Redirect during stall=1 and a miss -> new addresses load, epoch increments, state RUN.
//  - Target la=0xFFFFFFF, NUM_BANKS=2, accept both -> wrap to 0x0000001 and 0x0000000; 2**EPOCH_W redirects wrap epoch to 0.

Source files
------------

// File: rtl/fetch_line_sequencer_if.sv
// Bundle between the BP/WB redirect logic, the I$ banks and fetch-2 on one
// side and the fetch line sequencer on the other.
//   master : redirect/bank-status side; drives init, resteer, branch, stall,
//            accept and miss, and receives the bank requests.
//   slave  : the sequencer; receives those inputs and drives bank_req,
//            bank_la (bank 0 in LSBs), epoch, redirect and entry_off.
interface fetch_line_sequencer_if #(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned LA_W      = 28,
    parameter int unsigned EPOCH_W   = 3
);
    logic [31:0]               init_addr;
    logic                      is_init;
    logic                      is_resteer;
    logic [LA_W-1:0]           wb_la;
    logic                      is_br_taken;
    logic [LA_W-1:0]           bp_la;
    logic                      stall;
    logic [NUM_BANKS-1:0]      bank_accept;
    logic [NUM_BANKS-1:0]      bank_miss;
    logic [NUM_BANKS-1:0]      bank_req;
    logic [NUM_BANKS*LA_W-1:0] bank_la;
    logic [EPOCH_W-1:0]        epoch;
    logic                      redirect;
    logic [3:0]                entry_off;

    modport master (
        output init_addr, is_init, is_resteer, wb_la, is_br_taken, bp_la,
        output stall, bank_accept, bank_miss,
        input  bank_req, bank_la, epoch, redirect, entry_off
    );

    modport slave (
        input  init_addr, is_init, is_resteer, wb_la, is_br_taken, bp_la,
        input  stall, bank_accept, bank_miss,
        output bank_req, bank_la, epoch, redirect, entry_off
    );
endinterface

// File: rtl/fetch_line_sequencer.sv
// Fetch line-address generator for a NUM_BANKS-way interleaved I$.
// Selects a redirect target (init > WB resteer > BP taken), loads each bank
// with the first line at or after the target that maps to it, then advances
// every bank independently by NUM_BANKS lines on accept. Missed banks hold
// their address; each redirect bumps the stream epoch.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : fetch_line_sequencer_if.slave (redirect inputs, bank status,
//           bank_req/bank_la/epoch/redirect/entry_off outputs)
module fetch_line_sequencer #(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned LA_W      = 28,
    parameter int unsigned EPOCH_W   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_line_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StMiss} state_e;

    state_e state_q, state_d;

    logic [NUM_BANKS-1:0][LA_W-1:0] bank_la_q;
    logic [NUM_BANKS-1:0][LA_W-1:0] load_la;
    logic [EPOCH_W-1:0]             epoch_q;
    logic                           redirect_q;
    logic [3:0]                     entry_off_q;

    logic                           redirect_taken;
    logic [LA_W-1:0]                target;
    logic [LA_W-1:0]                bank_mask;
    logic [LA_W-1:0]                base;
    logic [LA_W-1:0]                first_bank;
    logic [NUM_BANKS-1:0]           advance;

    // Resteer and branch are only meaningful once a stream has been started.
    assign redirect_taken = bus.is_init |
                            ((state_q != StIdle) & (bus.is_resteer | bus.is_br_taken));

    always_comb begin
        if (bus.is_init) begin
            target = LA_W'(bus.init_addr[31:4]);
        end else if (bus.is_resteer) begin
            target = bus.wb_la;
        end else begin
            target = bus.bp_la;
        end
    end

    assign bank_mask  = LA_W'(NUM_BANKS - 1);
    assign base       = target & ~bank_mask;
    assign first_bank = target & bank_mask;

    // Banks below the target's bank already passed the target in this
    // group, so they start one group later. Sums wrap modulo 2**LA_W.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (LA_W'(b) >= first_bank) begin
                load_la[b] = base + LA_W'(b);
            end else begin
                load_la[b] = base + LA_W'(NUM_BANKS) + LA_W'(b);
            end
        end
    end

    // Miss beats accept on the same bank; stall and redirect freeze all.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            advance[b] = (state_q != StIdle) & bus.bank_accept[b] & ~bus.bank_miss[b] &
                         ~bus.stall & ~redirect_taken;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.is_init) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (redirect_taken) begin
                    state_d = StRun;
                end else if (|bus.bank_miss) begin
                    state_d = StMiss;
                end
            end
            StMiss: begin
                if (redirect_taken || (bus.bank_miss == '0)) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.bank_req  = {NUM_BANKS{state_q != StIdle}};
        bus.bank_la   = bank_la_q;
        bus.epoch     = epoch_q;
        bus.redirect  = redirect_q;
        bus.entry_off = entry_off_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_la_q   <= '0;
            epoch_q     <= '0;
            redirect_q  <= 1'b0;
            entry_off_q <= 4'd0;
        end else begin
            redirect_q <= redirect_taken;
            if (redirect_taken) begin
                bank_la_q   <= load_la;
                epoch_q     <= epoch_q + 1'b1;
                entry_off_q <= bus.is_init ? bus.init_addr[3:0] : 4'd0;
            end else begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (advance[b]) begin
                        bank_la_q[b] <= bank_la_q[b] + LA_W'(NUM_BANKS);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_line_sequencer.sv
module tb_fetch_line_sequencer;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_line_sequencer_if #(.NUM_BANKS(2), .LA_W(28), .EPOCH_W(3)) b2 ();
    fetch_line_sequencer_if #(.NUM_BANKS(4), .LA_W(28), .EPOCH_W(3)) b4 ();

    fetch_line_sequencer #(.NUM_BANKS(2), .LA_W(28), .EPOCH_W(3)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2.slave)
    );

    fetch_line_sequencer #(.NUM_BANKS(4), .LA_W(28), .EPOCH_W(3)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk2(input string tag, input logic [27:0] l0, input logic [27:0] l1);
        chk({tag, ".la0"}, 64'(b2.bank_la[27:0]), 64'(l0));
        chk({tag, ".la1"}, 64'(b2.bank_la[55:28]), 64'(l1));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        b2.init_addr = '0; b2.is_init = 0; b2.is_resteer = 0; b2.wb_la = '0;
        b2.is_br_taken = 0; b2.bp_la = '0; b2.stall = 0; b2.bank_accept = '0;
        b2.bank_miss = '0;
        b4.init_addr = '0; b4.is_init = 0; b4.is_resteer = 0; b4.wb_la = '0;
        b4.is_br_taken = 0; b4.bp_la = '0; b4.stall = 0; b4.bank_accept = '0;
        b4.bank_miss = '0;
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset values.
        chk("rst.req", 64'(b2.bank_req), 64'd0);
        chk2("rst", 28'h0, 28'h0);
        chk("rst.epoch", 64'(b2.epoch), 64'd0);
        chk("rst.redirect", 64'(b2.redirect), 64'd0);
        chk("rst.entry_off", 64'(b2.entry_off), 64'd0);
        chk("rst.state", 64'(dut2.state_q), 64'd0);

        // IDLE ignores resteer and branch.
        b2.is_resteer = 1; b2.wb_la = 28'h5; b2.is_br_taken = 1; b2.bp_la = 28'h9;
        step();
        chk("idle.epoch", 64'(b2.epoch), 64'd0);
        chk("idle.req", 64'(b2.bank_req), 64'd0);
        chk("idle.redirect", 64'(b2.redirect), 64'd0);
        b2.is_resteer = 0; b2.is_br_taken = 0;

        // Init at 0x14: T=1 -> bank0=2, bank1=1. NB=4 init at 0 in parallel.
        b2.is_init = 1; b2.init_addr = 32'h0000_0014;
        b4.is_init = 1; b4.init_addr = 32'h0000_0000;
        step();
        chk2("init", 28'h2, 28'h1);
        chk("init.entry_off", 64'(b2.entry_off), 64'd4);
        chk("init.epoch", 64'(b2.epoch), 64'd1);
        chk("init.redirect", 64'(b2.redirect), 64'd1);
        chk("init.req", 64'(b2.bank_req), 64'h3);
        chk("init.state", 64'(dut2.state_q), 64'd1);
        b2.is_init = 0;
        b4.is_init = 0;

        // NB=4 resteer to 0x102 wins over a same-cycle BP taken.
        b4.is_resteer = 1; b4.wb_la = 28'h102; b4.is_br_taken = 1; b4.bp_la = 28'h55;
        // NB=2 accepts bank 0 only for 3 cycles.
        b2.bank_accept = 2'b01;
        step();
        chk("nb4.la0", 64'(b4.bank_la[27:0]), 64'h104);
        chk("nb4.la1", 64'(b4.bank_la[55:28]), 64'h105);
        chk("nb4.la2", 64'(b4.bank_la[83:56]), 64'h102);
        chk("nb4.la3", 64'(b4.bank_la[111:84]), 64'h103);
        chk("nb4.epoch", 64'(b4.epoch), 64'd2);
        chk("nb4.req", 64'(b4.bank_req), 64'hF);
        chk("acc0.redirect", 64'(b2.redirect), 64'd0);
        chk2("acc0.c1", 28'h4, 28'h1);
        b4.is_resteer = 0; b4.is_br_taken = 0;
        step();
        step();
        chk2("acc0.c3", 28'h8, 28'h1);

        // Bank 1 misses for 5 cycles with both accepting.
        b2.bank_accept = 2'b11; b2.bank_miss = 2'b10;
        step();
        chk("miss.state", 64'(dut2.state_q), 64'd2);
        chk2("miss.c1", 28'hA, 28'h1);
        step(); step(); step(); step();
        chk2("miss.c5", 28'h12, 28'h1);
        chk("miss.req", 64'(b2.bank_req), 64'h3);
        b2.bank_accept = 2'b00; b2.bank_miss = 2'b00;
        step();
        chk("miss.clear", 64'(dut2.state_q), 64'd1);
        chk2("miss.hold", 28'h12, 28'h1);

        // Stall with misses and accepts: nothing advances.
        b2.stall = 1; b2.bank_miss = 2'b11; b2.bank_accept = 2'b11;
        step();
        chk2("stall", 28'h12, 28'h1);
        chk("stall.state", 64'(dut2.state_q), 64'd2);

        // Branch redirect overrides stall and miss.
        b2.is_br_taken = 1; b2.bp_la = 28'h40;
        step();
        chk2("brst", 28'h40, 28'h41);
        chk("brst.epoch", 64'(b2.epoch), 64'd2);
        chk("brst.state", 64'(dut2.state_q), 64'd1);
        chk("brst.entry_off", 64'(b2.entry_off), 64'd0);
        b2.is_br_taken = 0; b2.stall = 0; b2.bank_miss = 2'b00; b2.bank_accept = 2'b00;

        // Resteer to the top line wins over branch, then wraps.
        b2.is_resteer = 1; b2.wb_la = 28'hFFF_FFFF; b2.is_br_taken = 1; b2.bp_la = 28'h7;
        step();
        chk2("wrap.load", 28'h0, 28'hFFF_FFFF);
        chk("wrap.epoch", 64'(b2.epoch), 64'd3);
        b2.is_resteer = 0; b2.is_br_taken = 0;
        b2.bank_accept = 2'b11;
        step();
        chk2("wrap.adv", 28'h2, 28'h1);
        b2.bank_accept = 2'b00;

        // Five more redirects: epoch 3 -> 8 wraps to 0.
        b2.is_br_taken = 1; b2.bp_la = 28'h10;
        step(); step(); step(); step(); step();
        chk("ep.wrap", 64'(b2.epoch), 64'd0);
        chk2("ep.la", 28'h10, 28'h11);
        chk("ep.redirect", 64'(b2.redirect), 64'd1);
        b2.is_br_taken = 0;

        // Re-init while running beats resteer: T=3 -> bank0=4, bank1=3.
        b2.is_init = 1; b2.init_addr = 32'h0000_0037; b2.is_resteer = 1; b2.wb_la = 28'h80;
        step();
        chk2("reinit", 28'h4, 28'h3);
        chk("reinit.entry_off", 64'(b2.entry_off), 64'd7);
        chk("reinit.epoch", 64'(b2.epoch), 64'd1);
        b2.is_init = 0; b2.is_resteer = 0;

        // Asynchronous reset mid-stream, away from any clock edge.
        step();
        chk("pre.redirect", 64'(b2.redirect), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk2("arst", 28'h0, 28'h0);
        chk("arst.epoch", 64'(b2.epoch), 64'd0);
        chk("arst.req", 64'(b2.bank_req), 64'd0);
        chk("arst.entry_off", 64'(b2.entry_off), 64'd0);
        chk("arst.nb4", 64'(b4.bank_la[27:0]), 64'd0);
        step();
        reset = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
